// File: rtl/rd_return_reorder_pkg.sv
// Shared read-path types for the front end: index/data widths and the reorder-slot state.
package types_def;

    localparam int read_entries_log = 4;
    localparam int data_width       = 32;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        FILLED  = 2'd2
    } slot_state_t;

    typedef logic [read_entries_log-1:0] idx_t;
    typedef logic [data_width-1:0]       data_t;

endpackage

// File: rtl/rd_return_reorder.sv
// Read-return reorder buffer: hands out indices in order, accepts tagged responses out of order,
// releases data in allocation order. Define RD_REORDER_CHECK_EN to drop and flag illegal responses.
module rd_return_reorder
    import types_def::*;
#(
    parameter int entries_no = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alloc_valid_i,
    output logic                              alloc_grant_o,
    output logic [read_entries_log-1:0]       alloc_index_o,
    input  logic                              resp_valid_i,
    input  logic [read_entries_log-1:0]       resp_index_i,
    input  logic [data_width-1:0]             resp_data_i,
    output logic                              valid_o,
    output logic [data_width-1:0]             data_o,
    output logic [read_entries_log-1:0]       index_o,
    input  logic                              grant_i,
    output logic [$clog2(entries_no+1)-1:0]   count_o,
    output logic                              err_o
);

    localparam int                        cnt_w    = $clog2(entries_no + 1);
    localparam idx_t                      last_idx = idx_t'(entries_no - 1);
    localparam logic [cnt_w-1:0]          full_cnt = cnt_w'(entries_no);
    localparam logic [read_entries_log:0] bound    = (read_entries_log + 1)'(entries_no);

    slot_state_t       state      [entries_no];
    slot_state_t       state_next [entries_no];
    data_t             storage    [entries_no];
    idx_t              head;
    idx_t              tail;
    logic [cnt_w-1:0]  count;

    logic alloc_fire;
    logic pop_fire;
    logic resp_in_range;
    logic resp_accept;

    assign alloc_grant_o = (count < full_cnt);
    assign alloc_index_o = tail;
    assign valid_o       = (state[head] == FILLED);
    assign data_o        = storage[head];
    assign index_o       = head;
    assign count_o       = count;

    assign alloc_fire    = alloc_valid_i && alloc_grant_o;
    assign pop_fire      = valid_o && grant_i;
    assign resp_in_range = ({1'b0, resp_index_i} < bound);

`ifdef RD_REORDER_CHECK_EN
    assign resp_accept = resp_valid_i && resp_in_range && (state[resp_index_i] == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (resp_valid_i && !resp_accept) begin
            err_o <= 1'b1;
        end
    end
`else
    // Out-of-range indices have no slot to write, so they are ignored even without checking.
    assign resp_accept = resp_valid_i && resp_in_range;
    assign err_o       = 1'b0;
`endif

    // Allocation, response and pop always address distinct slots, so their order here is immaterial.
    always_comb begin
        for (int i = 0; i < entries_no; i++) begin
            state_next[i] = state[i];
            if (alloc_fire && (tail == idx_t'(i))) begin
                state_next[i] = PENDING;
            end
            if (resp_accept && (resp_index_i == idx_t'(i))) begin
                state_next[i] = FILLED;
            end
            if (pop_fire && (head == idx_t'(i))) begin
                state_next[i] = FREE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < entries_no; i++) begin
                state[i] <= FREE;
            end
        end else begin
            for (int i = 0; i < entries_no; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < entries_no; i++) begin
                storage[i] <= '0;
            end
        end else if (resp_accept) begin
            storage[resp_index_i] <= resp_data_i;
        end
    end

    // Explicit wrap keeps the pointers correct for depths that are not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= (tail == last_idx) ? '0 : tail + idx_t'(1);
            end
            if (pop_fire) begin
                head <= (head == last_idx) ? '0 : head + idx_t'(1);
            end
            if (alloc_fire && !pop_fire) begin
                count <= count + cnt_w'(1);
            end else if (pop_fire && !alloc_fire) begin
                count <= count - cnt_w'(1);
            end
        end
    end

endmodule

// File: tb/tb_rd_return_reorder.sv
// Bench for rd_return_reorder (12 slots): directed scenarios plus random traffic against a queue model.
module tb_rd_return_reorder;
    import types_def::*;

    localparam int N  = 12;
    localparam int CW = $clog2(N + 1);

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic                        alloc_valid_i = 1'b0;
    logic                        alloc_grant_o;
    logic [read_entries_log-1:0] alloc_index_o;
    logic                        resp_valid_i = 1'b0;
    logic [read_entries_log-1:0] resp_index_i = '0;
    logic [data_width-1:0]       resp_data_i = '0;
    logic                        valid_o;
    logic [data_width-1:0]       data_o;
    logic [read_entries_log-1:0] index_o;
    logic                        grant_i = 1'b0;
    logic [CW-1:0]               count_o;
    logic                        err_o;

    always #5 clk = ~clk;

    rd_return_reorder #(.entries_no(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid_i (alloc_valid_i),
        .alloc_grant_o (alloc_grant_o),
        .alloc_index_o (alloc_index_o),
        .resp_valid_i  (resp_valid_i),
        .resp_index_i  (resp_index_i),
        .resp_data_i   (resp_data_i),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .index_o       (index_o),
        .grant_i       (grant_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding indices in allocation order, per-slot fill flag and data.
    int                    q[$];
    bit                    filled[N];
    logic [data_width-1:0] mdata[N];
    int                    tail_m;
    bit                    err_m;

    function automatic int head_m();
        return (q.size() > 0) ? q[0] : tail_m;
    endfunction

    function automatic bit is_pending(input int i);
        foreach (q[k]) if (q[k] == i) return !filled[i];
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            filled[i] = 1'b0;
            mdata[i]  = '0;
        end
        tail_m = 0;
        err_m  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit vld;
        vld = (q.size() > 0) && filled[q[0]];
        chk("count_o", 64'(count_o), 64'(q.size()));
        chk("alloc_grant_o", 64'(alloc_grant_o), 64'(q.size() < N));
        chk("alloc_index_o", 64'(alloc_index_o), 64'(tail_m));
        chk("valid_o", 64'(valid_o), 64'(vld));
        chk("index_o", 64'(index_o), 64'(head_m()));
        chk("data_o", 64'(data_o), 64'(mdata[head_m()]));
        chk("err_o", 64'(err_o), 64'(err_m));
    endtask

    // Called just after a falling edge: drive one cycle, advance the model, check after the next fall.
    task automatic cycle(input bit a, input bit r, input int ri, input logic [data_width-1:0] rd,
                         input bit g);
        bit vld;
        bit grt;
        bit pop;
        bit alc;
        bit in_rng;
        alloc_valid_i = a;
        resp_valid_i  = r;
        resp_index_i  = read_entries_log'(ri);
        resp_data_i   = rd;
        grant_i       = g;
        vld    = (q.size() > 0) && filled[q[0]];
        grt    = (q.size() < N);
        pop    = vld && g;
        alc    = a && grt;
        in_rng = r && (ri >= 0) && (ri < N);
`ifdef RD_REORDER_CHECK_EN
        if (r) begin
            if (in_rng && is_pending(ri)) begin
                filled[ri] = 1'b1;
                mdata[ri]  = rd;
            end else begin
                err_m = 1'b1;
            end
        end
`else
        if (in_rng) begin
            filled[ri] = 1'b1;
            mdata[ri]  = rd;
        end
`endif
        if (pop) begin
            filled[q[0]] = 1'b0;
            void'(q.pop_front());
        end
        if (alc) begin
            q.push_back(tail_m);
            filled[tail_m] = 1'b0;
            tail_m = (tail_m + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        alloc_valid_i = 1'b0;
        resp_valid_i  = 1'b0;
        grant_i       = 1'b0;
    endtask

    task automatic mid_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    task automatic drain();
        int guard;
        int ri;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            ri = -1;
            foreach (q[k]) begin
                if (!filled[q[k]]) begin
                    ri = q[k];
                    break;
                end
            end
            if (ri >= 0) cycle(1'b0, 1'b1, ri, $urandom, 1'b1);
            else         cycle(1'b0, 1'b0, 0, '0, 1'b1);
            guard++;
        end
        chk("drain_count", 64'(count_o), 64'd0);
    endtask

    initial begin
        int base;
        int pc[$];
        bit a;
        bit g;
        bit r;
        int ri;

        // Power-on reset
        model_reset();
        #1 rst_n = 1'b0;
        #8;
        check_outputs();
        chk("rst_grant", 64'(alloc_grant_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // In-order flow
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, i, 32'hA000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("inorder_data", 64'(data_o), 64'(32'hA000_0000 + 32'(i)));
            chk("inorder_index", 64'(index_o), 64'(i));
            cycle(1'b0, 1'b0, 0, '0, 1'b1);
        end
        chk("inorder_count", 64'(count_o), 64'd0);

        // Out-of-order responses, in-order release
        base = tail_m;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0, '0, 1'b1);
        cycle(1'b0, 1'b1, (base + 3) % N, 32'hB3, 1'b1);
        chk("ooo_hold3", 64'(valid_o), 64'd0);
        cycle(1'b0, 1'b1, (base + 1) % N, 32'hB1, 1'b1);
        cycle(1'b0, 1'b1, (base + 2) % N, 32'hB2, 1'b1);
        chk("ooo_hold2", 64'(valid_o), 64'd0);
        cycle(1'b0, 1'b1, base, 32'hB0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("ooo_index", 64'(index_o), 64'((base + i) % N));
            chk("ooo_data", 64'(data_o), 64'(32'hB0 + 32'(i)));
            cycle(1'b0, 1'b0, 0, '0, 1'b1);
        end

        // Mid-run reset with 3 pending
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, '0, 1'b0);
        mid_reset();
        chk("post_rst_index", 64'(alloc_index_o), 64'd0);

        // Fill to full, then free one slot
        for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, 0, '0, 1'b0);
        chk("full_grant", 64'(alloc_grant_o), 64'd0);
        cycle(1'b1, 1'b0, 0, '0, 1'b0);
        cycle(1'b0, 1'b1, 0, 32'hC0, 1'b0);
        cycle(1'b1, 1'b0, 0, '0, 1'b1);
        chk("regrant", 64'(alloc_grant_o), 64'd1);
        chk("wrap_index", 64'(alloc_index_o), 64'd0);
        cycle(1'b1, 1'b0, 0, '0, 1'b0);

        // Pop, allocate and respond in one cycle
        cycle(1'b0, 1'b1, 1, 32'hD1, 1'b0);
        cycle(1'b0, 1'b0, 0, '0, 1'b1);
        cycle(1'b0, 1'b1, 2, 32'hD2, 1'b0);
        chk("simul_pre_count", 64'(count_o), 64'd11);
        cycle(1'b1, 1'b1, 3, 32'hD3, 1'b1);
        chk("simul_count", 64'(count_o), 64'd11);
        chk("simul_valid", 64'(valid_o), 64'd1);
        chk("simul_data", 64'(data_o), 64'h0D3);
        drain();

`ifdef RD_REORDER_CHECK_EN
        // Illegal responses are dropped and flagged
        cycle(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0);
        chk("err_set", 64'(err_o), 64'd1);
        cycle(1'b0, 1'b1, 13, 32'hBAD0_000D, 1'b0);
        cycle(1'b1, 1'b0, 0, '0, 1'b0);
        chk("err_sticky", 64'(err_o), 64'd1);
        drain();
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            pc.delete();
            foreach (q[j]) if (!filled[q[j]]) pc.push_back(q[j]);
            a  = ($urandom_range(3, 0) != 0);
            g  = ($urandom_range(2, 0) != 0);
            r  = (pc.size() > 0) && ($urandom_range(2, 0) != 0);
            ri = r ? pc[$urandom_range(pc.size() - 1, 0)] : 0;
`ifdef RD_REORDER_CHECK_EN
            if ($urandom_range(19, 0) == 0) begin
                r  = 1'b1;
                ri = $urandom_range(15, 0);
            end
`endif
            cycle(a, r, ri, $urandom, g);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rd_return_reorder.md
# rd_return_reorder

- Read-return path of the front end, opposite direction to the request FIFO.
- Hands out read indices in program order when read requests are issued.
- Accepts read-data responses from the back end out of order, tagged with that index.
- Releases data to the requester strictly in allocation order with a valid/grant handshake.

## Interface
Parameters:
- entries_no, default 16: number of reorder slots; must be ≤ 2**read_entries_log; need not be a power of two.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  front end requests an index for a read being issued
- alloc_grant_o  out  1  slot available; allocation occurs on valid&grant
- alloc_index_o  out  read_entries_log  index allocated this cycle (tail pointer)
- resp_valid_i  in  1  back end read response valid (no backpressure, always accepted)
- resp_index_i  in  read_entries_log  slot index carried with the response
- resp_data_i  in  data_width  read data
- valid_o  out  1  head slot holds data
- data_o  out  data_width  head slot data
- index_o  out  read_entries_log  head pointer value
- grant_i  in  1  consumer accepts head; pop on valid_o&grant_i
- count_o  out  $clog2(entries_no+1)  allocated slots (PENDING+FILLED)
- err_o  out  1  sticky protocol error (see Configuration)

## Operation
- Per-slot state machine: FREE, PENDING, FILLED.
  - Allocate: FREE -> PENDING.
  - Response: PENDING -> FILLED, data stored.
  - Pop: FILLED -> FREE.
- Tail pointer: advances on allocation. Head pointer: advances on pop. Both wrap from entries_no-1 to 0.
- Count update:
  - allocate only: +1
  - pop only: -1
  - both in the same cycle: unchanged
- alloc_grant_o = (count < entries_no). It uses the registered count only; a pop in the same cycle does not open a grant while full.
- alloc_index_o always equals the tail pointer, including when there is no grant.
- A response writes slot[resp_index_i] and makes it FILLED from the next cycle.
- valid_o = (state[head] == FILLED). data_o and index_o come combinationally from registered head and storage.
- A response to the head slot in cycle N gives valid_o in cycle N+1 (one-cycle latency minimum).
- Response, allocation and pop may all occur in the same cycle; they always target different slots and all take effect.

## Timing
Reset, asynchronous:
- All slots FREE; storage cleared to 0; head = tail = 0; count = 0.
- Outputs: valid_o=0, data_o=0, index_o=0, alloc_grant_o=1, alloc_index_o=0, count_o=0, err_o=0.

Reset asserted mid-operation:
- All in-flight indices are discarded.
- The first allocation after release gets index 0.

Boundary cases:
- Empty (count=0): valid_o=0. A response to a FREE slot is an error case.
- Full (count=entries_no): alloc_grant_o=0. Popping makes the grant 1 in the next cycle.
- Head FILLED while grant_i=0: valid_o, data_o and index_o stay stable until the pop.

## Configuration
- Macro RD_REORDER_CHECK_EN.
- Defined: a response whose resp_index_i slot is not PENDING, or is ≥ entries_no, is dropped.
  - No state or data change.
  - err_o is set and stays 1 until reset.
- Undefined: no check. Any response writes data and sets the slot FILLED; err_o is tied 0.

## Structure
- Package types_def supplies read_entries_log and data_width.
- Add to types_def: slot_state_t enum (FREE, PENDING, FILLED, 2 bits) for reuse by the back-end response arbiter.
- Single module, no sub-modules. Pointer wrap logic is inline, matching the request FIFO's handling of non-power-of-two depths.

## Test plan
- In-order: allocate 0,1,2; respond 0,1,2 with data A0,A1,A2; grant_i=1 -> data_o A0,A1,A2 with index_o 0,1,2 in consecutive cycles; count returns to 0.
- Out-of-order: allocate 0..3; respond 3,1,2,0 -> valid_o stays 0 until index 0 lands, then 4 back-to-back pops in order 0,1,2,3.
- Full with entries_no=12: allocate 12 -> alloc_grant_o=0. Respond index 0 and pop it -> grant returns next cycle; next alloc_index_o=0 (wrap).
- Simultaneous: same cycle as popping the head, allocate a new index and respond to another slot -> count unchanged, both effects visible next cycle.
- Error (RD_REORDER_CHECK_EN defined): respond to a FREE slot 5 -> err_o=1 next cycle and stays 1; slot 5 still FREE; a later valid flow is unaffected.
- Mid-run reset: reset with 3 slots PENDING -> all outputs at reset values; first allocation afterwards returns index 0.
